// File: rtl/req_pkg.sv
// Shared types and defaults for the burst request initiator.
package req_pkg;

  localparam int unsigned DefLenW    = 8;
  localparam int unsigned DefTimeout = 16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StXfer,
    StDone
  } req_state_e;

endpackage

// File: rtl/req_initiator_if.sv
// Command, arbitration and status bundle for req_initiator.
interface req_initiator_if
  import req_pkg::*;
#(
  parameter int unsigned LEN_W = DefLenW
) ();

  logic             start;
  logic [LEN_W-1:0] len;
  logic             gnt;
  logic             dly;
  logic             req;
  logic             done;
  logic             busy;
  logic             beat;
  logic [LEN_W-1:0] beat_cnt;
  logic             timeout_err;

  modport master (
    output start, len, gnt, dly,
    input  req, done, busy, beat, beat_cnt, timeout_err
  );

  modport slave (
    input  start, len, gnt, dly,
    output req, done, busy, beat, beat_cnt, timeout_err
  );

endinterface

// File: rtl/req_beat_counter.sv
// Beat counter with terminal-count flag; o_last is high while the next beat is the final one.
module req_beat_counter #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [LEN_W-1:0] i_len,
  output logic [LEN_W-1:0] o_count,
  output logic             o_last
);

  logic [LEN_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + LEN_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == (i_len - LEN_W'(1)));

endmodule

// File: rtl/req_initiator.sv
// Burst request initiator: requests the bus, counts granted beats, pulses done at burst end.
// Optional REQ_TIMEOUT_EN aborts a request after TIMEOUT consecutive no-grant cycles.
module req_initiator
  import req_pkg::*;
#(
  parameter int unsigned LEN_W   = DefLenW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input logic            clk,
  input logic            rst,
  req_initiator_if.slave bus
);

  req_state_e       r_state, w_state_next;
  logic [LEN_W-1:0] r_len;
  logic             r_req, r_done;
  logic             w_start_ok, w_beat, w_last, w_timeout;

  assign w_beat = (r_state == StXfer) && bus.gnt && !bus.dly;

`ifdef REQ_TIMEOUT_EN
  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WaitW-1:0] r_wait_cnt;
  logic             r_timeout_err;

  assign w_timeout = (r_state == StReq) && !bus.gnt && (r_wait_cnt == WaitW'(TIMEOUT - 1));

  // Cleared on every entry into REQ, including a return from XFER on lost grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if ((w_state_next == StReq) && (r_state != StReq)) begin
        r_wait_cnt <= '0;
      end else if ((r_state == StReq) && !bus.gnt && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + WaitW'(1);
      end
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_timeout       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start && (bus.len != '0)) begin
          w_start_ok   = 1'b1;
          w_state_next = StReq;
        end
      end
      StReq: begin
        if (bus.gnt) begin
          w_state_next = StXfer;
        end else if (w_timeout) begin
          w_state_next = StIdle;
        end
      end
      StXfer: begin
        if (!bus.gnt) begin
          w_state_next = StReq;
        end else if (!bus.dly && w_last) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_req   <= (w_state_next == StReq) || (w_state_next == StXfer);
      r_done  <= (w_state_next == StDone);
      if (w_start_ok) begin
        r_len <= bus.len;
      end
    end
  end

  req_beat_counter #(
    .LEN_W (LEN_W)
  ) u_beat_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start_ok),
    .i_en    (w_beat),
    .i_len   (r_len),
    .o_count (bus.beat_cnt),
    .o_last  (w_last)
  );

  assign bus.req  = r_req;
  assign bus.done = r_done;
  assign bus.busy = (r_state != StIdle);
  assign bus.beat = w_beat;

endmodule

// File: tb/tb_req_initiator.sv
// Directed self-checking bench for req_initiator; cycle 0 is the cycle in which start is driven.
module tb_req_initiator;

  localparam int unsigned LenW    = 8;
  localparam int unsigned Timeout = 16;
`ifdef REQ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  req_initiator_if #(.LEN_W(LenW)) u_if ();

  req_initiator #(
    .LEN_W   (LenW),
    .TIMEOUT (Timeout)
  ) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (u_if.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    u_if.start = 1'b0;
    u_if.len   = '0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    u_if.gnt   = 1'b1;
    u_if.dly   = 1'b0;
    u_if.start = 1'b0;
    u_if.len   = 8'd3;
    rst_n      = 1'b0;
    #22;
    n_checks++;
    if ({u_if.req, u_if.done, u_if.beat, u_if.busy, u_if.timeout_err, u_if.beat_cnt} !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_state: got req/done/beat/busy/tmo/cnt=%b want all zero",
               {u_if.req, u_if.done, u_if.beat, u_if.busy, u_if.timeout_err, u_if.beat_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // len=3, constant grant; a second start mid-burst with len=7 must be ignored.
  task automatic test_basic();
    logic [6:0] e_req  = 7'b0011110;
    logic [6:0] e_beat = 7'b0011100;
    logic [6:0] e_done = 7'b0100000;
    logic [6:0] e_busy = 7'b0111110;
    u_if.gnt = 1'b1;
    u_if.dly = 1'b0;
    for (int c = 0; c < 7; c++) begin
      u_if.start = (c == 0) || (c == 3);
      u_if.len   = (c == 0) ? 8'd3 : 8'd7;
      @(negedge clk);
      n_checks++;
      if ({u_if.req, u_if.done, u_if.beat, u_if.busy} !== {e_req[c], e_done[c], e_beat[c], e_busy[c]}) begin
        n_errors++;
        $display("FAIL basic c%0d: got req,done,beat,busy=%b want %b", c,
                 {u_if.req, u_if.done, u_if.beat, u_if.busy},
                 {e_req[c], e_done[c], e_beat[c], e_busy[c]});
      end
      if (c == 5) begin
        n_checks++;
        if (u_if.beat_cnt !== 8'd3) begin
          n_errors++;
          $display("FAIL basic_cnt: got %0d want 3", u_if.beat_cnt);
        end
      end
      tick();
    end
    u_if.start = 1'b0;
  endtask

  // len=4, stall in the 2nd and 3rd XFER cycles (c3, c4): done moves from c6 to c8.
  task automatic test_stall();
    logic [9:0] e_req  = 10'b0011111110;
    logic [9:0] e_beat = 10'b0011100100;
    logic [9:0] e_done = 10'b0100000000;
    u_if.gnt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      u_if.start = (c == 0);
      u_if.len   = 8'd4;
      u_if.dly   = (c == 3) || (c == 4);
      @(negedge clk);
      n_checks++;
      if ({u_if.req, u_if.done, u_if.beat} !== {e_req[c], e_done[c], e_beat[c]}) begin
        n_errors++;
        $display("FAIL stall c%0d: got req,done,beat=%b want %b", c,
                 {u_if.req, u_if.done, u_if.beat}, {e_req[c], e_done[c], e_beat[c]});
      end
      if (c == 4 || c == 8) begin
        n_checks++;
        if (u_if.beat_cnt !== ((c == 4) ? 8'd1 : 8'd4)) begin
          n_errors++;
          $display("FAIL stall_cnt c%0d: got %0d want %0d", c, u_if.beat_cnt, (c == 4) ? 1 : 4);
        end
      end
      tick();
    end
    u_if.start = 1'b0;
    u_if.dly   = 1'b0;
  endtask

  // len=5, grant lost for c4..c6 after two beats; resumes and finishes at c11.
  task automatic test_regrant();
    logic [12:0] e_req  = 13'b0011111111110;
    logic [12:0] e_beat = 13'b0011100001100;
    logic [12:0] e_done = 13'b0100000000000;
    u_if.dly = 1'b0;
    for (int c = 0; c < 13; c++) begin
      u_if.start = (c == 0);
      u_if.len   = 8'd5;
      u_if.gnt   = !((c >= 4) && (c <= 6));
      @(negedge clk);
      n_checks++;
      if ({u_if.req, u_if.done, u_if.beat} !== {e_req[c], e_done[c], e_beat[c]}) begin
        n_errors++;
        $display("FAIL regrant c%0d: got req,done,beat=%b want %b", c,
                 {u_if.req, u_if.done, u_if.beat}, {e_req[c], e_done[c], e_beat[c]});
      end
      if (c == 6) begin
        n_checks++;
        if ({u_if.busy, u_if.beat_cnt} !== {1'b1, 8'd2}) begin
          n_errors++;
          $display("FAIL regrant_hold: got busy=%b cnt=%0d want busy=1 cnt=2",
                   u_if.busy, u_if.beat_cnt);
        end
      end
      tick();
    end
    u_if.start = 1'b0;
    u_if.gnt   = 1'b1;
  endtask

  task automatic test_timeout();
    logic exp_req, exp_tmo;
    u_if.gnt = 1'b0;
    u_if.dly = 1'b0;
    for (int c = 0; c < 19; c++) begin
      u_if.start = (c == 0);
      u_if.len   = 8'd2;
      exp_req    = TmoEn ? ((c >= 1) && (c <= 16)) : (c >= 1);
      exp_tmo    = TmoEn && (c == 17);
      @(negedge clk);
      n_checks++;
      if ({u_if.req, u_if.done, u_if.timeout_err} !== {exp_req, 1'b0, exp_tmo}) begin
        n_errors++;
        $display("FAIL timeout c%0d: got req,done,tmo=%b want %b", c,
                 {u_if.req, u_if.done, u_if.timeout_err}, {exp_req, 1'b0, exp_tmo});
      end
      tick();
    end
    u_if.gnt = 1'b1;
    apply_reset();
  endtask

  task automatic test_reset_mid();
    u_if.gnt = 1'b1;
    u_if.dly = 1'b0;
    for (int c = 0; c < 5; c++) begin
      u_if.start = (c == 0);
      u_if.len   = 8'd5;
      tick();
    end
    u_if.start = 1'b0;
    n_checks++;
    if ({u_if.beat, u_if.beat_cnt} !== {1'b1, 8'd3}) begin
      n_errors++;
      $display("FAIL mid_pre: got beat=%b cnt=%0d want beat=1 cnt=3", u_if.beat, u_if.beat_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({u_if.req, u_if.done, u_if.beat, u_if.busy, u_if.timeout_err, u_if.beat_cnt} !== 13'd0) begin
      n_errors++;
      $display("FAIL mid_async: got req/done/beat/busy/tmo/cnt=%b want all zero",
               {u_if.req, u_if.done, u_if.beat, u_if.busy, u_if.timeout_err, u_if.beat_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      u_if.start = (c == 1);
      u_if.len   = 8'd0;
      tick();
      @(negedge clk);
      n_checks++;
      if ({u_if.done, u_if.timeout_err, u_if.busy, u_if.req} !== 4'b0000) begin
        n_errors++;
        $display("FAIL mid_release c%0d: got done,tmo,busy,req=%b want 0000", c,
                 {u_if.done, u_if.timeout_err, u_if.busy, u_if.req});
      end
    end
    u_if.start = 1'b0;
    tick();
  endtask

  task automatic test_max_len();
    int n_beats = 0;
    int done_c  = -1;
    u_if.gnt = 1'b1;
    u_if.dly = 1'b0;
    for (int c = 0; c < 300; c++) begin
      u_if.start = (c == 0);
      u_if.len   = 8'd255;
      @(negedge clk);
      if (u_if.beat) n_beats++;
      if (u_if.done && done_c < 0) begin
        done_c = c;
        n_checks++;
        if (u_if.beat_cnt !== 8'd255) begin
          n_errors++;
          $display("FAIL maxlen_cnt: got %0d want 255", u_if.beat_cnt);
        end
      end
      tick();
    end
    u_if.start = 1'b0;
    n_checks++;
    if (n_beats != 255) begin
      n_errors++;
      $display("FAIL maxlen_beats: got %0d want 255", n_beats);
    end
    n_checks++;
    if (done_c != 257) begin
      n_errors++;
      $display("FAIL maxlen_done_cycle: got %0d want 257", done_c);
    end
  endtask

  initial begin
    u_if.start = 1'b0;
    u_if.len   = '0;
    u_if.gnt   = 1'b0;
    u_if.dly   = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_regrant();
    test_timeout();
    test_reset_mid();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/req_initiator.md
REQ_INITIATOR -- requirements
Module: req_initiator

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of burst length and beat counter.
REQ-002 SHALL have parameter TIMEOUT, default 16, consecutive no-grant cycles in REQ before abort (used only with REQ_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle command to begin a burst.
REQ-006 SHALL have port len  input  LEN_W  burst length in beats, sampled with start.
REQ-007 SHALL have port gnt  input  1  grant from arbiter FSM.
REQ-008 SHALL have port dly  input  1  responder stall; no beat while high.
REQ-009 SHALL have port req  output  1  registered bus request to arbiter.
REQ-010 SHALL have port done  output  1  registered one-cycle burst-complete pulse.
REQ-011 SHALL have port busy  output  1  high in any state except IDLE.
REQ-012 SHALL have port beat  output  1  combinational: state==XFER & gnt & ~dly.
REQ-013 SHALL have port beat_cnt  output  LEN_W  beats completed in current burst.
REQ-014 SHALL have port timeout_err  output  1  registered one-cycle abort pulse.

Function
REQ-015 SHALL implement states IDLE, REQ, XFER, DONE.
REQ-016 IDLE: start=1 and len!=0 SHALL latch len, clear beat_cnt, enter REQ; req=1 on next cycle (1-cycle latency).
REQ-017 IDLE: start=1 with len==0 SHALL be ignored (no state change, no done).
REQ-018 start outside IDLE SHALL be ignored; len not re-sampled.
REQ-019 REQ: req=1; gnt=1 SHALL move to XFER next cycle regardless of dly.
REQ-020 XFER: req held 1; each cycle with beat=1 SHALL increment beat_cnt; dly=1 stalls, beat_cnt held.
REQ-021 XFER: beat=1 when beat_cnt==len-1 SHALL enter DONE; done=1, req=0 in DONE; then IDLE next cycle.
REQ-022 XFER: gnt=0 SHALL return to REQ, no beat that cycle, beat_cnt retained; burst resumes on re-grant.
REQ-023 gnt=0 and dly=1 together in XFER SHALL behave per REQ-022.
REQ-024 len=2^LEN_W-1 SHALL complete exactly that many beats; beat_cnt SHALL never wrap within a burst.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE; req, done, timeout_err, beat_cnt = 0; busy=0; beat=0.
REQ-026 Reset mid-burst SHALL discard the burst; no done or timeout_err pulse on release.

Configuration
REQ-027 With REQ_TIMEOUT_EN defined: a wait counter SHALL clear on every REQ entry and count REQ cycles with gnt=0; on the TIMEOUT-th such cycle, next cycle SHALL be IDLE with req=0, timeout_err=1 for one cycle, no done.
REQ-028 Without REQ_TIMEOUT_EN: REQ SHALL wait for gnt indefinitely; timeout_err tied 0; no wait counter.

Structure
REQ-029 Shared package req_pkg SHALL hold the state encoding typedef and default LEN_W/TIMEOUT constants.
REQ-030 Beat counting with terminal-count compare SHALL be sub-module req_beat_counter (clear, enable, len, count, last).

Verification
REQ-031 gnt=1 constant, dly=0, start at cycle 0 with len=3 -> req=1 cycle 1; beat cycles 2,3,4; done=1, req=0 cycle 5; busy=0 cycle 6.
REQ-032 len=4, dly=1 in 2nd and 3rd XFER cycles -> beat_cnt holds, 4 beats total, done 2 cycles later than no-stall case.
REQ-033 len=5, gnt dropped after 2 beats for 3 cycles -> state REQ, req stays 1, beat_cnt=2 held; after re-grant 3 more beats then done.
REQ-034 REQ_TIMEOUT_EN, TIMEOUT=16, gnt=0, start at cycle 0 -> req=1 cycles 1-16; cycle 17 req=0, timeout_err=1, done=0; without macro req stays 1.
REQ-035 rst=0 asynchronously mid-XFER with beat_cnt=3 -> outputs 0 immediately; after release no done; start with len=0 -> busy stays 0.
